// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
// Holds the SPECIAL decode values, the FSM state encoding and the divide-by-zero LO value.
package muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [31:0] DIVZERO_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the ID/EX pipeline side (master) and the mul/div unit (slave).
// Stall protocol: while o_stall is high the master holds every i_* field (ID/EX frozen);
// the instruction in EX is consumed on the first falling edge with i_step=1 and o_stall=0.
interface ex_muldiv_if #(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6,
    parameter int NB_CNT    = 6
);
    import muldiv_pkg::*;

    logic                 i_step;
    logic [NB_OPCODE-1:0] i_instruction_op_code;
    logic [NB_FCODE-1:0]  i_instruction_funct_code;
    logic [NB-1:0]        i_data_a;
    logic [NB-1:0]        i_data_b;
    logic                 o_stall;
    logic                 o_result_sel;
    logic [NB-1:0]        o_result;
    logic [NB-1:0]        o_hi;
    logic [NB-1:0]        o_lo;
    state_t               o_dbg_state;
    logic [NB_CNT-1:0]    o_dbg_cnt;

    modport master (
        output i_step, i_instruction_op_code, i_instruction_funct_code, i_data_a, i_data_b,
        input  o_stall, o_result_sel, o_result, o_hi, o_lo, o_dbg_state, o_dbg_cnt
    );

    modport slave (
        input  i_step, i_instruction_op_code, i_instruction_funct_code, i_data_a, i_data_b,
        output o_stall, o_result_sel, o_result, o_hi, o_lo, o_dbg_state, o_dbg_cnt
    );

endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative engine: radix-2 shift-add multiply or restoring divide on unsigned magnitudes,
// one bit per falling step edge, with the iteration counter.
module muldiv_iter #(
    parameter int NB     = 32,
    parameter int NB_CNT = 6
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_step,
    input  logic              i_start,
    input  logic              i_run,
    input  logic              i_div,
    input  logic [NB-1:0]     i_a,
    input  logic [NB-1:0]     i_b,
    output logic              o_last,
    output logic [NB_CNT-1:0] o_cnt,
    output logic [2*NB-1:0]   o_acc
);

    logic [2*NB-1:0]   acc_q, acc_d;
    logic [NB-1:0]     b_q, b_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic [NB:0]       add_sum;
    logic [NB:0]       rem_shift;
    logic [NB:0]       rem_diff;

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps the remainder in the high half and shifts quotient bits into the low half.
    always_comb begin
        add_sum   = {1'b0, acc_q[2*NB-1:NB]} + (acc_q[0] ? {1'b0, b_q} : {(NB+1){1'b0}});
        rem_shift = acc_q[2*NB-1:NB-1];
        rem_diff  = rem_shift - {1'b0, b_q};
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        if (i_start) begin
            acc_d = {{NB{1'b0}}, i_a};
            b_d   = i_b;
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = cnt_q + NB_CNT'(1);
            if (i_div) begin
                if (rem_diff[NB]) acc_d = {rem_shift[NB-1:0], acc_q[NB-2:0], 1'b0};
                else              acc_d = {rem_diff[NB-1:0], acc_q[NB-2:0], 1'b1};
            end else begin
                acc_d = {add_sum, acc_q[NB-1:1]};
            end
        end
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (i_step) begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_last = (cnt_q == NB_CNT'(NB - 1));
    assign o_cnt  = cnt_q;
    assign o_acc  = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: FSM, sign handling, architectural HI/LO and result muxing.
// All state moves on the falling clock edge, together with the pipeline registers.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6,
    parameter int NB_CNT    = 6
) (
    input logic        i_clk,
    input logic        i_reset_n,
    ex_muldiv_if.slave bus
);

    state_t              state_q, state_d;
    logic [NB-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d, is_div_q, is_div_d;

    logic                is_special;
    logic [NB_FCODE-1:0] fn;
    logic                op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic                op_signed, op_div, start_op, div_zero;
    logic                a_neg, b_neg;
    logic [NB-1:0]       a_mag, b_mag;
    logic                iter_start, iter_run, iter_last;
    logic [NB_CNT-1:0]   iter_cnt;
    logic [2*NB-1:0]     iter_acc, prod;
    logic [NB-1:0]       quot, rem;

    always_comb begin
        is_special = (bus.i_instruction_op_code == NB_OPCODE'(OP_SPECIAL));
        fn         = bus.i_instruction_funct_code;
        op_mfhi    = is_special && (fn == NB_FCODE'(FN_MFHI));
        op_mthi    = is_special && (fn == NB_FCODE'(FN_MTHI));
        op_mflo    = is_special && (fn == NB_FCODE'(FN_MFLO));
        op_mtlo    = is_special && (fn == NB_FCODE'(FN_MTLO));
        op_signed  = is_special && ((fn == NB_FCODE'(FN_MULT)) || (fn == NB_FCODE'(FN_DIV)));
        op_div     = is_special && ((fn == NB_FCODE'(FN_DIV)) || (fn == NB_FCODE'(FN_DIVU)));
        start_op   = op_div || (is_special &&
                     ((fn == NB_FCODE'(FN_MULT)) || (fn == NB_FCODE'(FN_MULTU))));
        div_zero   = op_div && (bus.i_data_b == '0);
        a_neg      = op_signed && bus.i_data_a[NB-1];
        b_neg      = op_signed && bus.i_data_b[NB-1];
        a_mag      = a_neg ? -bus.i_data_a : bus.i_data_a;
        b_mag      = b_neg ? -bus.i_data_b : bus.i_data_b;
    end

    assign iter_start = (state_q == ST_IDLE) && start_op;
    assign iter_run   = (state_q == ST_MUL) || (state_q == ST_DIV);

    muldiv_iter #(.NB(NB), .NB_CNT(NB_CNT)) u_iter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (bus.i_step),
        .i_start   (iter_start),
        .i_run     (iter_run),
        .i_div     (state_q == ST_DIV),
        .i_a       (a_mag),
        .i_b       (b_mag),
        .o_last    (iter_last),
        .o_cnt     (iter_cnt),
        .o_acc     (iter_acc)
    );

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_IDLE;
        else if (bus.i_step) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_op) state_d = div_zero ? ST_DONE : (op_div ? ST_DIV : ST_MUL);
            ST_MUL, ST_DIV: if (iter_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // On divide-by-zero the engine still holds |a| in its low half, so re-applying the
    // dividend sign reconstructs the raw a for HI.
    always_comb begin
        prod      = neg_q ? -iter_acc : iter_acc;
        quot      = iter_acc[NB-1:0];
        rem       = iter_acc[2*NB-1:NB];
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        case (state_q)
            ST_IDLE: begin
                if (start_op) begin
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = div_zero;
                    is_div_d  = op_div;
                end else if (op_mthi) begin
                    hi_d = bus.i_data_a;
                end else if (op_mtlo) begin
                    lo_d = bus.i_data_a;
                end
            end
            ST_DONE: begin
                if (dz_q) begin
                    hi_d = rem_neg_q ? -quot : quot;
                    lo_d = NB'(DIVZERO_LO);
                end else if (is_div_q) begin
                    hi_d = rem_neg_q ? -rem : rem;
                    lo_d = neg_q ? -quot : quot;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: ;
        endcase
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
        end else if (bus.i_step) begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
        end
    end

    always_comb begin
        bus.o_stall      = i_reset_n && (((state_q == ST_IDLE) && start_op) ||
                                         (state_q == ST_MUL) || (state_q == ST_DIV));
        bus.o_result_sel = i_reset_n && (op_mfhi || op_mflo);
        bus.o_result     = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);
        bus.o_hi         = hi_q;
        bus.o_lo         = lo_q;
        bus.o_dbg_state  = state_q;
        bus.o_dbg_cnt    = iter_cnt;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage directly downstream of the ID/EX pipeline register. It consumes the decoded op/funct codes and operands held in ID/EX. It executes MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO/MFHI/MFLO. While an iteration is in progress it raises a stall that freezes the PC, IF/ID and ID/EX.

## Interface
- NB, 32, datapath width
- NB_OPCODE, 6, opcode width
- NB_FCODE, 6, funct width
- NB_CNT, 6, iteration counter width; must hold NB
- i_clk  in  1  pipeline clock; all state changes on falling edge, same edge as the pipeline registers
- i_reset_n  in  1  reset, asynchronous, active-low
- i_step  in  1  debug step enable; state changes only when high
- i_instruction_op_code  in  NB_OPCODE  opcode from ID/EX
- i_instruction_funct_code  in  NB_FCODE  funct from ID/EX
- i_data_a  in  NB  rs operand (forwarded)
- i_data_b  in  NB  rt operand (forwarded)
- o_stall  out  1  freeze PC, IF/ID and ID/EX, and bubble EX/MEM
- o_result_sel  out  1  EX result mux takes o_result instead of the ALU result (MFHI/MFLO)
- o_result  out  NB  HI for MFHI, LO for MFLO, else 0
- o_hi  out  NB  current HI, for the debug unit
- o_lo  out  NB  current LO, for the debug unit

## Operation
- Decode applies only when opcode == 0 (SPECIAL). Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- A bubble (all zeros) decodes as SLL and is a no-op for this block.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on a start op, latch |a| and |b| (absolute values only for MULT/DIV), latch the result-sign flags, clear the counter, then go to MUL or DIV.
  - IDLE, DIV/DIVU with b == 0: go directly to DONE with the div-by-zero flag set.
  - MUL: radix-2 shift-add into a 2*NB accumulator, one bit per edge.
  - DIV: restoring shift-subtract, one bit per edge.
  - MUL/DIV: counter increments each edge; on the NB-th iteration go to DONE.
  - DONE: write HI/LO with sign correction, then go to IDLE. A start op is ignored in DONE.
- Sign rules:
  - Product sign = sa^sb.
  - Quotient sign = sa^sb.
  - Remainder sign = sa.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0 with no trap.
- Divide by zero: HI = a, LO = 0xFFFFFFFF.
- MTHI/MTLO: in IDLE, write i_data_a to HI/LO on the step edge.
- MFHI/MFLO: o_result_sel=1 and o_result=HI/LO, combinational from the registers.
- o_stall = (IDLE and start op) or MUL or DIV. It is combinational and low in DONE.
- Reset (any time, including mid-iteration):
  - state=IDLE; HI, LO, accumulators and counter = 0.
  - o_stall=0, o_result_sel=0, o_result=0, o_hi=0, o_lo=0.
- i_step low: all state frozen; outputs keep their values.

## Timing
- "Edge" below means a falling edge with i_step=1.
- Start edge: IDLE→MUL/DIV.
- NB iteration edges follow, the last one entering DONE.
- o_stall is high from start-op presentation through the NB+1 edges, so 33 stalled edges for NB=32.
- The DONE edge commits HI/LO. On that same edge the pipeline advances. A following MFHI/MFLO sees the new value on the next cycle, with no extra interlock.
- Divide by zero takes 2 edges: start edge → DONE, then commit. o_stall is high for 1 edge.
- MTHI immediately followed by MFHI: HI is written on the edge the MTHI leaves EX, so the MFHI reads the new value.
- Start op while the FSM is not IDLE is impossible, because ID/EX is frozen. DONE ignores the start op still held in ID/EX.

## Structure
- Package muldiv_pkg holds:
  - the funct constants and the SPECIAL opcode;
  - the FSM state typedef (2-bit);
  - DIVZERO_LO = 32'hFFFFFFFF.
- Sub-module muldiv_iter holds the accumulator, shift/add/subtract step and counter, with start/mode/done ports.
- ex_muldiv keeps the FSM, sign handling, HI/LO and the output muxing.

## Test plan
- MULT a=-3 (0xFFFFFFFD), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_stall high exactly 33 edges.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=14, HI=2.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIV 9/0 → HI=9, LO=0xFFFFFFFF after 2 edges, o_stall high for 1 edge.
- MULT in progress:
  - drop i_step for 5 cycles → counter, state and o_stall frozen; then completes with the correct result;
  - pull i_reset_n low at iteration 10 → immediate IDLE, HI=LO=0, o_stall=0.
- MTHI 0x12345678, then MFHI → o_result_sel=1, o_result=0x12345678; MFLO after reset → o_result=0.
